// File: rtl/shift_issue_ctrl.sv
// Issue/retire controller for a LAT-stage pipelined barrel shifter: command FIFO, credit-gated issue,
// tag pipeline and result FIFO. Define SHIFT_ISSUE_STATS_EN to add op_count/stall_count outputs.
module shift_issue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int RDEPTH = 4,
  parameter int LAT    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_amt,
  input  logic        in_right,
  output logic [31:0] sh_I,
  output logic [4:0]  sh_S,
  output logic        sh_R,
  input  logic [31:0] sh_O,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  inflight
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic [15:0] stall_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RDEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  amt;
    logic        right;
  } cmd_t;

  cmd_t          cmd_mem_q [DEPTH];
  logic [AW-1:0] cmd_wp_q, cmd_rp_q;
  logic [AW:0]   cmd_cnt_q, cmd_cnt_d;

  logic [31:0]   res_mem_q [RDEPTH];
  logic [RW-1:0] res_wp_q, res_rp_q;
  logic [RW:0]   res_cnt_q, res_cnt_d;

  logic [LAT:0]  tag_q, tag_d;
  logic [2:0]    infl_q, infl_d;
  logic [31:0]   sh_i_q;
  logic [4:0]    sh_s_q;
  logic          sh_r_q;

  logic          push, issue, wr, pop, credit;
  logic [7:0]    occ;

  // Credit uses registered counts only; a same-edge pop frees its slot one edge later.
  assign occ       = 8'(infl_q) + 8'(res_cnt_q);
  assign credit    = occ < 8'(RDEPTH);
  assign in_ready  = cmd_cnt_q != (AW+1)'(DEPTH);
  assign push      = in_valid && in_ready;
  assign issue     = (cmd_cnt_q != '0) && credit;
  assign wr        = tag_q[LAT];
  assign out_valid = res_cnt_q != '0;
  assign pop       = out_valid && out_ready;
  assign out_data  = res_mem_q[res_rp_q];
  assign inflight  = infl_q;
  assign sh_I      = sh_i_q;
  assign sh_S      = sh_s_q;
  assign sh_R      = sh_r_q;

  always_comb begin
    cmd_cnt_d = cmd_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
    res_cnt_d = res_cnt_q + (RW+1)'(wr) - (RW+1)'(pop);
    infl_d    = infl_q + 3'(issue) - 3'(wr);
    tag_d     = {tag_q[LAT-1:0], issue};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) cmd_mem_q[i] <= '0;
      for (int i = 0; i < RDEPTH; i++) res_mem_q[i] <= '0;
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
      res_wp_q  <= '0;
      res_rp_q  <= '0;
      res_cnt_q <= '0;
      tag_q     <= '0;
      infl_q    <= '0;
      sh_i_q    <= '0;
      sh_s_q    <= '0;
      sh_r_q    <= 1'b0;
    end else begin
      if (push) begin
        cmd_mem_q[cmd_wp_q] <= {in_data, in_amt, in_right};
        cmd_wp_q            <= cmd_wp_q + 1'b1;
      end
      if (issue) begin
        sh_i_q   <= cmd_mem_q[cmd_rp_q].data;
        sh_s_q   <= cmd_mem_q[cmd_rp_q].amt;
        sh_r_q   <= cmd_mem_q[cmd_rp_q].right;
        cmd_rp_q <= cmd_rp_q + 1'b1;
      end
      if (wr) begin
        res_mem_q[res_wp_q] <= sh_O;
        res_wp_q            <= res_wp_q + 1'b1;
      end
      if (pop) res_rp_q <= res_rp_q + 1'b1;
      cmd_cnt_q <= cmd_cnt_d;
      res_cnt_q <= res_cnt_d;
      infl_q    <= infl_d;
      tag_q     <= tag_d;
    end
  end

`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] op_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
      if ((cmd_cnt_q != '0) && !credit && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign op_count    = op_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
